// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the serial_adder block.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the step counter for an n-step operation (at least one bit).
    function automatic int step_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder used as one slice of the serial adder's ripple chain.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle ripple adder: computes x + y + z in WIDTH/BITS_PER_CYCLE steps,
// LSB slice first, with valid/ready handshakes on both sides.
// Optional feature: define SERIAL_ADDER_SUBTRACT_EN to add a `sub` input that
// turns the operation into x - y - z (z acts as borrow-in).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SERIAL_ADDER_SUBTRACT_EN
    input  logic             sub,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V
);

    localparam int B  = BITS_PER_CYCLE;
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = step_cnt_w(N);

    if (BITS_PER_CYCLE < 1 || WIDTH < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("serial_adder: BITS_PER_CYCLE must divide WIDTH");
    end

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             carry;
    logic             v_q;
    logic [B-1:0]     slice_s;
    logic [B:0]       rc;
    logic [WIDTH+B-1:0] s_cat;
    logic             accept;
    logic             last_step;

    assign in_ready  = !rst && (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign last_step = (cnt == CW'(N - 1));
    assign out_valid = (state == DONE);
    assign S         = s_sh;
    assign C         = carry;
    assign V         = v_q;

    // Ripple slice over the low B bits of the operand shift registers.
    assign rc[0] = carry;
    for (genvar i = 0; i < B; i++) begin : g_slice
        fa_cell u_fa (
            .a   (a_sh[i]),
            .b   (b_sh[i]),
            .cin (rc[i]),
            .s   (slice_s[i]),
            .cout(rc[i+1])
        );
    end

    // New sum slice enters the result register from the top.
    assign s_cat = {slice_s, s_sh} >> B;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = ADD;
            ADD:     if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Datapath: operand latch, per-step slice add, result and flag capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            v_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh <= x;
`ifdef SERIAL_ADDER_SUBTRACT_EN
                        b_sh  <= sub ? ~y : y;
                        carry <= sub ? ~z : z;
`else
                        b_sh  <= y;
                        carry <= z;
`endif
                        cnt  <= '0;
                    end
                end
                ADD: begin
                    a_sh  <= a_sh >> B;
                    b_sh  <= b_sh >> B;
                    s_sh  <= s_cat[WIDTH-1:0];
                    carry <= rc[B];
                    // On the final step rc[B-1] is the carry into the MSB.
                    v_q   <= rc[B-1] ^ rc[B];
                    cnt   <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: a 4-bit/1-bit-per-step instance and an
// 8-bit/2-bit-per-step instance, checked against an arithmetic model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       sub4;
    logic       in_valid4, in_valid8;
    logic       rdy4, rdy8;
    logic [3:0] x4, y4;
    logic [7:0] x8, y8;
    logic       z4, z8;
    logic       ov4, ov8;
    logic       ordy4, ordy8;
    logic [3:0] s4;
    logic [7:0] s8;
    logic       c4, c8, v4, v8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(1)) dut4 (
        .clk(clk), .rst(rst),
`ifdef SERIAL_ADDER_SUBTRACT_EN
        .sub(sub4),
`endif
        .in_valid(in_valid4), .in_ready(rdy4), .x(x4), .y(y4), .z(z4),
        .out_valid(ov4), .out_ready(ordy4), .S(s4), .C(c4), .V(v4)
    );

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(2)) dut8 (
        .clk(clk), .rst(rst),
`ifdef SERIAL_ADDER_SUBTRACT_EN
        .sub(1'b0),
`endif
        .in_valid(in_valid8), .in_ready(rdy8), .x(x8), .y(y8), .z(z8),
        .out_valid(ov8), .out_ready(ordy8), .S(s8), .C(c8), .V(v8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {V, C, S[7:0]} for a w-bit add (or subtract) using plain integers.
    function automatic logic [9:0] model(input int w, input logic [7:0] xa, input logic [7:0] ya,
                                         input logic za, input logic sb);
        int xi, yi, zi, sx, sy, full, sres, lim;
        logic [7:0] s;
        logic c, v;
        xi  = int'(xa) & ((1 << w) - 1);
        yi  = int'(ya) & ((1 << w) - 1);
        zi  = int'(za);
        lim = 1 << (w - 1);
        sx  = (xi >= lim) ? xi - (1 << w) : xi;
        sy  = (yi >= lim) ? yi - (1 << w) : yi;
        if (sb) begin
            full = xi - yi - zi;
            c    = (full >= 0);
            sres = sx - sy - zi;
        end else begin
            full = xi + yi + zi;
            c    = ((full >> w) & 1) != 0;
            sres = sx + sy + zi;
        end
        s = 8'(full & ((1 << w) - 1));
        v = (sres > lim - 1) || (sres < -lim);
        return {v, c, s};
    endfunction

    // One full transaction; optionally hold DONE with out_ready low for `hold` cycles.
    task automatic run_op(input bit wide, input logic [7:0] xa, input logic [7:0] ya,
                          input logic za, input logic sb, input int hold, input string tag);
        logic [9:0] exp;
        int w, lat, guard;
        w     = wide ? 8 : 4;
        exp   = model(w, xa, ya, za, sb);
        guard = 0;
        while (!(wide ? rdy8 : rdy4) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " in_ready"}, 32'(wide ? rdy8 : rdy4), 32'd1);
        if (wide) begin
            in_valid8 = 1'b1; x8 = xa; y8 = ya; z8 = za;
        end else begin
            in_valid4 = 1'b1; x4 = xa[3:0]; y4 = ya[3:0]; z4 = za; sub4 = sb;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid4 = 1'b0; in_valid8 = 1'b0;
        x4 = 4'($urandom); y4 = 4'($urandom); x8 = 8'($urandom); y8 = 8'($urandom);
        lat = 0;
        while (!(wide ? ov8 : ov4) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd4);
        check({tag, " S"}, 32'(wide ? s8 : {4'b0, s4}), 32'(exp[7:0]));
        check({tag, " C"}, 32'(wide ? c8 : c4), 32'(exp[8]));
        if (!wide) check({tag, " V"}, 32'(v4), 32'(exp[9]));
        else       check({tag, " V"}, 32'(v8), 32'(exp[9]));
        for (int i = 0; i < hold; i++) begin
            in_valid4 = 1'b1; x4 = 4'($urandom); y4 = 4'($urandom); z4 = 1'($urandom);
            @(negedge clk);
            check({tag, " hold valid"}, 32'(ov4), 32'd1);
            check({tag, " hold ready"}, 32'(rdy4), 32'd0);
            check({tag, " hold S"}, 32'(s4), 32'(exp[3:0]));
            check({tag, " hold CV"}, 32'({v4, c4}), 32'(exp[9:8]));
        end
        in_valid4 = 1'b0;
        if (wide) ordy8 = 1'b1; else ordy4 = 1'b1;
        @(negedge clk);
        ordy4 = 1'b0; ordy8 = 1'b0;
        check({tag, " release valid"}, 32'(wide ? ov8 : ov4), 32'd0);
        check({tag, " release ready"}, 32'(wide ? rdy8 : rdy4), 32'd1);
    endtask

    initial begin
        rst = 1'b1; sub4 = 1'b0;
        in_valid4 = 1'b0; in_valid8 = 1'b0; ordy4 = 1'b0; ordy8 = 1'b0;
        x4 = '0; y4 = '0; z4 = 1'b0; x8 = '0; y8 = '0; z8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset S", 32'(s4), 32'd0);
        check("reset CV", 32'({c4, v4}), 32'd0);
        check("reset out_valid", 32'({ov4, ov8}), 32'd0);
        check("reset in_ready", 32'({rdy4, rdy8}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", 32'({rdy4, rdy8}), 32'b11);

        run_op(1'b0, 8'h1, 8'h0, 1'b0, 1'b0, 0, "basic 1+0");
        run_op(1'b0, 8'hF, 8'h1, 1'b0, 1'b0, 0, "F+1");
        run_op(1'b0, 8'h7, 8'h1, 1'b0, 1'b0, 0, "7+1 ovf");
        run_op(1'b0, 8'hF, 8'hF, 1'b1, 1'b0, 0, "F+F+1");

        for (int xi = 0; xi < 16; xi++)
            for (int yi = 0; yi < 16; yi++)
                for (int zi = 0; zi < 2; zi++)
                    run_op(1'b0, 8'(xi), 8'(yi), 1'(zi), 1'b0, 0, "exhaustive");

        // DONE held with out_ready low and new operands offered.
        run_op(1'b0, 8'h7, 8'h1, 1'b0, 1'b0, 5, "hold");

        // Reset in the middle of ADD abandons the operation.
        in_valid4 = 1'b1; x4 = 4'h3; y4 = 4'h5; z4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst S", 32'(s4), 32'd0);
        check("midrst out_valid", 32'(ov4), 32'd0);
        check("midrst in_ready", 32'(rdy4), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst idle", 32'(rdy4), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst no pulse", 32'(ov4), 32'd0);
        end

        // Reset and in_valid together: nothing accepted.
        rst = 1'b1; in_valid4 = 1'b1; x4 = 4'h2; y4 = 4'h2;
        @(negedge clk);
        rst = 1'b0; in_valid4 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst+valid idle", 32'({ov4, rdy4}), 32'b01);
        end

        // Wide instance, two bits per step.
        run_op(1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 0, "w8 FF+1+1");
        run_op(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 0, "w8 ovf");
        for (int i = 0; i < 24; i++)
            run_op(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 0, "w8 random");
        for (int i = 0; i < 24; i++)
            run_op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, $urandom_range(0, 2), "w4 random");

`ifdef SERIAL_ADDER_SUBTRACT_EN
        run_op(1'b0, 8'h5, 8'h3, 1'b0, 1'b1, 0, "sub 5-3");
        run_op(1'b0, 8'h3, 8'h5, 1'b0, 1'b1, 0, "sub 3-5");
        for (int i = 0; i < 24; i++)
            run_op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 0, "sub random");
        run_op(1'b0, 8'h6, 8'h2, 1'b1, 1'b0, 0, "sub0 add");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
